// File: rtl/nanorv32_parameters.sv
// Shared nanorv32 constants: TCM arbiter master IDs and the data-path width.
package nanorv32_parameters;

  localparam logic NANORV32_TCM_ARB_ID_I = 1'b0;
  localparam logic NANORV32_TCM_ARB_ID_D = 1'b1;

  localparam int unsigned NANORV32_DATA_WIDTH = 32;

endpackage

// File: rtl/nanorv32_tcm_arb_pick.sv
// Grant selection between the instruction and data masters of the TCM arbiter.
// NANORV32_TCM_ARB_RR_EN: round-robin on contention; otherwise D has fixed priority.
module nanorv32_tcm_arb_pick
  import nanorv32_parameters::*;
(
  input  logic i_elig,
  input  logic d_elig,
  input  logic last_gnt,
  output logic gnt_vld,
  output logic gnt_id
);

`ifndef NANORV32_TCM_ARB_RR_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  always_comb begin
    gnt_vld = i_elig | d_elig;
    gnt_id  = NANORV32_TCM_ARB_ID_I;
    if (i_elig && d_elig) begin
`ifdef NANORV32_TCM_ARB_RR_EN
      gnt_id = ~last_gnt;
`else
      gnt_id = NANORV32_TCM_ARB_ID_D;
`endif
    end else if (d_elig) begin
      gnt_id = NANORV32_TCM_ARB_ID_D;
    end
  end

endmodule

// File: rtl/nanorv32_tcm_arbiter.sv
// Two-master (I fetch / D load-store) front end for the nanorv32 TCM controller.
// Optional round-robin arbitration via NANORV32_TCM_ARB_RR_EN (see nanorv32_tcm_arb_pick).
module nanorv32_tcm_arbiter
  import nanorv32_parameters::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  output logic                           i_ack,
  output logic [NANORV32_DATA_WIDTH-1:0] i_rdata,
  input  logic                           d_req,
  input  logic [ADDR_WIDTH-1:0]          d_addr,
  input  logic [NANORV32_DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]                     d_bytesel,
  output logic                           d_ack,
  output logic [NANORV32_DATA_WIDTH-1:0] d_rdata,
  output logic                           tcm_en,
  output logic [ADDR_WIDTH-1:0]          tcm_addr,
  output logic [NANORV32_DATA_WIDTH-1:0] tcm_din,
  output logic [3:0]                     tcm_bytesel,
  input  logic [NANORV32_DATA_WIDTH-1:0] tcm_dout
);

  logic pend_q, pend_d;
  logic pend_id_q, pend_id_d;
  logic last_gnt_q, last_gnt_d;

  logic ret_i, ret_d;
  logic i_elig, d_elig;
  logic gnt_vld, gnt_id, gnt_d;
  logic issue_wr, issue_rd;

  // A master whose read returns this cycle is being acked and must not reissue.
  always_comb begin
    ret_i  = pend_q && (pend_id_q == NANORV32_TCM_ARB_ID_I);
    ret_d  = pend_q && (pend_id_q == NANORV32_TCM_ARB_ID_D);
    i_elig = i_req && !ret_i;
    d_elig = d_req && !ret_d;
  end

  nanorv32_tcm_arb_pick u_pick (
    .i_elig   (i_elig),
    .d_elig   (d_elig),
    .last_gnt (last_gnt_q),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  always_comb begin
    gnt_d    = gnt_vld && (gnt_id == NANORV32_TCM_ARB_ID_D);
    issue_wr = gnt_d && (d_bytesel != 4'b0000);
    issue_rd = gnt_vld && !issue_wr;

    tcm_en      = gnt_vld;
    tcm_addr    = '0;
    if (gnt_vld) begin
      tcm_addr = gnt_d ? d_addr : i_addr;
    end
    tcm_din     = gnt_d ? d_wdata : '0;
    tcm_bytesel = gnt_d ? d_bytesel : '0;

    i_ack   = ret_i;
    i_rdata = ret_i ? tcm_dout : '0;
    d_ack   = ret_d || issue_wr;
    d_rdata = ret_d ? tcm_dout : '0;

    pend_d     = issue_rd;
    pend_id_d  = issue_rd ? gnt_id : pend_id_q;
    last_gnt_d = gnt_vld ? gnt_id : last_gnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_id_q  <= NANORV32_TCM_ARB_ID_I;
      last_gnt_q <= NANORV32_TCM_ARB_ID_D;
    end else begin
      pend_q     <= pend_d;
      pend_id_q  <= pend_id_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_nanorv32_tcm_arbiter.sv
// Self-checking bench for nanorv32_tcm_arbiter: directed scenarios plus random two-master traffic.
module tb_nanorv32_tcm_arbiter;

`ifdef NANORV32_TCM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [11:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [11:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_bytesel = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        tcm_en;
  logic [11:0] tcm_addr;
  logic [31:0] tcm_din;
  logic [3:0]  tcm_bytesel;
  logic [31:0] tcm_dout = '0;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];

  nanorv32_tcm_arbiter #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_bytesel(d_bytesel),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .tcm_en(tcm_en), .tcm_addr(tcm_addr), .tcm_din(tcm_din),
    .tcm_bytesel(tcm_bytesel), .tcm_dout(tcm_dout)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h required %h", nm, $time, act, exp);
    end
  endtask

  // Synchronous RAM standing in for the controller: registered read data.
  always @(posedge clk) begin
    if (tcm_en) begin
      if (tcm_bytesel == 4'b0000) begin
        tcm_dout <= mem[tcm_addr[11:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (tcm_bytesel[b]) mem[tcm_addr[11:2]][8*b +: 8] = tcm_din[8*b +: 8];
      end
    end
  end

  // Reference model: one scheduled return (who, data) and the last granted master.
  bit          m_ret_v;
  bit          m_ret_d;
  logic [31:0] m_ret_data;
  bit          m_last_d = 1'b1;

  always @(negedge clk) begin
    bit ie, de, gv, gd, gwr;
    logic [11:0] ea;
    if (!rst_n) begin
      m_ret_v  = 1'b0;
      m_last_d = 1'b1;
      cmp("rst_tcm_en",  32'(tcm_en), 32'd0);
      cmp("rst_i_ack",   32'(i_ack), 32'd0);
      cmp("rst_d_ack",   32'(d_ack), 32'd0);
      cmp("rst_i_rdata", i_rdata, 32'd0);
      cmp("rst_d_rdata", d_rdata, 32'd0);
      cmp("rst_tcm_bytesel", 32'(tcm_bytesel), 32'd0);
    end else begin
      ie = i_req && !(m_ret_v && !m_ret_d);
      de = d_req && !(m_ret_v && m_ret_d);
      gv = ie || de;
      if (ie && de) gd = RR_EN ? !m_last_d : 1'b1;
      else          gd = de;
      gwr = gv && gd && (d_bytesel != 4'b0000);
      ea  = !gv ? 12'h000 : (gd ? d_addr : i_addr);

      cmp("m_tcm_en",      32'(tcm_en), 32'(gv));
      cmp("m_tcm_addr",    32'(tcm_addr), 32'(ea));
      cmp("m_tcm_din",     tcm_din, (gv && gd) ? d_wdata : 32'd0);
      cmp("m_tcm_bytesel", 32'(tcm_bytesel), (gv && gd) ? 32'(d_bytesel) : 32'd0);
      cmp("m_i_ack",   32'(i_ack), 32'(m_ret_v && !m_ret_d));
      cmp("m_i_rdata", i_rdata, (m_ret_v && !m_ret_d) ? m_ret_data : 32'd0);
      cmp("m_d_ack",   32'(d_ack), 32'((m_ret_v && m_ret_d) || gwr));
      cmp("m_d_rdata", d_rdata, (m_ret_v && m_ret_d) ? m_ret_data : 32'd0);

      if (gv) m_last_d = gd;
      if (gv && !gwr) begin
        m_ret_v    = 1'b1;
        m_ret_d    = gd;
        m_ret_data = shadow[ea[11:2]];
      end else begin
        m_ret_v = 1'b0;
      end
      if (gwr)
        for (int b = 0; b < 4; b++)
          if (d_bytesel[b]) shadow[d_addr[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic i_master(input int n);
    for (int k = 0; k < n; k++) begin
      bit got = 1'b0;
      i_addr = 12'($urandom_range(0, 15) << 2);
      i_req  = 1'b1;
      for (int c = 0; c < 64 && !got; c++) begin
        @(negedge clk);
        got = i_ack;
      end
      tests++;
      if (!got) begin
        fails++;
        $display("FAIL i_timeout: i_ack got 0 required 1 within 64 cycles");
      end
      tick();
      i_req = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic d_master(input int n);
    for (int k = 0; k < n; k++) begin
      bit got = 1'b0;
      d_addr    = 12'($urandom_range(0, 15) << 2);
      d_wdata   = $urandom;
      d_bytesel = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      d_req     = 1'b1;
      for (int c = 0; c < 64 && !got; c++) begin
        @(negedge clk);
        got = d_ack;
      end
      tests++;
      if (!got) begin
        fails++;
        $display("FAIL d_timeout: d_ack got 0 required 1 within 64 cycles");
      end
      tick();
      d_req = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit gd, prev_gd;
    for (int w = 0; w < 1024; w++) begin
      mem[w]    = 32'(w) * 32'h9E3779B1 ^ 32'h5A5A5A5A;
      shadow[w] = mem[w];
    end
    mem[4] = 32'hDEADBEEF;  shadow[4] = 32'hDEADBEEF;
    mem[8] = 32'hAABBCCDD;  shadow[8] = 32'hAABBCCDD;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lone I read
    tick();
    i_req = 1'b1; i_addr = 12'h010;
    @(negedge clk);
    cmp("ird_en",      32'(tcm_en), 32'd1);
    cmp("ird_bytesel", 32'(tcm_bytesel), 32'd0);
    cmp("ird_addr",    32'(tcm_addr), 32'h010);
    tick();
    @(negedge clk);
    cmp("ird_ack",     32'(i_ack), 32'd1);
    cmp("ird_data",    i_rdata, 32'hDEADBEEF);
    cmp("ird_noreiss", 32'(tcm_en), 32'd0);
    tick();
    i_req = 1'b0;

    // D partial write then read back
    d_req = 1'b1; d_addr = 12'h020; d_bytesel = 4'b0011; d_wdata = 32'h12345678;
    @(negedge clk);
    cmp("dwr_ack",     32'(d_ack), 32'd1);
    cmp("dwr_bytesel", 32'(tcm_bytesel), 32'h3);
    tick();
    d_bytesel = 4'b0000;
    @(negedge clk);
    cmp("drd_issue", 32'(tcm_en), 32'd1);
    cmp("drd_noack", 32'(d_ack), 32'd0);
    tick();
    @(negedge clk);
    cmp("drd_ack",  32'(d_ack), 32'd1);
    cmp("drd_data", d_rdata, 32'hAABB5678);
    tick();
    d_req = 1'b0;

    // I read return coincides with D write issue
    i_req = 1'b1; i_addr = 12'h030;
    @(negedge clk);
    tick();
    d_req = 1'b1; d_addr = 12'h034; d_bytesel = 4'b1111; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    cmp("both_i_ack", 32'(i_ack), 32'd1);
    cmp("both_d_ack", 32'(d_ack), 32'd1);
    cmp("both_wr_bs", 32'(tcm_bytesel), 32'hF);
    tick();
    i_req = 1'b0; d_bytesel = 4'b0000;
    @(negedge clk);
    tick();
    @(negedge clk);
    cmp("both_rdback", d_rdata, 32'hCAFEF00D);
    tick();
    d_req = 1'b0;

    // Same master held: one issue every second cycle
    i_req = 1'b1; i_addr = 12'h040;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cmp("hold_en",  32'(tcm_en), 32'(c % 2 == 0));
      cmp("hold_ack", 32'(i_ack), 32'(c % 2 == 1));
      tick();
    end
    i_req = 1'b0;

    // Reset during an I read's return-pending cycle
    i_req = 1'b1; i_addr = 12'h010;
    @(negedge clk);
    cmp("rst_pre_en", 32'(tcm_en), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0; i_req = 1'b0;
    @(negedge clk);
    cmp("rst_drop_ack", 32'(i_ack), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Contention straight out of reset (last_gnt = D)
    i_req = 1'b1; i_addr = 12'h100;
    d_req = 1'b1; d_addr = 12'h200; d_bytesel = 4'b0000;
    prev_gd = 1'b0;
    for (int c = 0; c < 8; c++) begin
      gd = RR_EN ? (c % 2 == 1) : (c % 2 == 0);
      @(negedge clk);
      cmp("cont_en",   32'(tcm_en), 32'd1);
      cmp("cont_addr", 32'(tcm_addr), gd ? 32'h200 : 32'h100);
      if (c > 0) begin
        cmp("cont_i_ack", 32'(i_ack), 32'(!prev_gd));
        cmp("cont_d_ack", 32'(d_ack), 32'(prev_gd));
      end
      prev_gd = gd;
      tick();
    end
    if (prev_gd) i_req = 1'b0; else d_req = 1'b0;
    @(negedge clk);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Random concurrent traffic
    fork
      i_master(150);
      d_master(150);
    join
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
